cpu_mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter between the CPU core's instruction and data ports and a single shared, pipelined synchronous SRAM. The core issues requests over a request/addr_ok/data_ok handshake. The block:
- picks one request per cycle;
- drives the SRAM;
- steers each response back to its originating port in issue order.

It sits directly downstream of the CPU top and replaces the separate inst/data SRAMs in the SoC wrapper.

---
 rtl/cpu_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arbiter
// Brief    : Arbitrates the CPU instruction and data ports onto one pipelined
//            SRAM. Responses return in grant order through a tag pipeline.
//            ARB_ROUND_ROBIN_EN selects round-robin (else data-over-inst).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic c_port_inst = 1'b0;
    localparam logic c_port_data = 1'b1;

    logic w_grant_inst;
    logic w_grant_data;
    logic w_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_ptr;

    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (resetn) begin
            if (inst_req && data_req) begin
                w_grant_inst = (r_rr_ptr == c_port_inst);
                w_grant_data = (r_rr_ptr == c_port_data);
            end else begin
                w_grant_inst = inst_req;
                w_grant_data = data_req;
            end
        end
    end

    // Preference flips to the port that did not just win.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr <= c_port_inst;
        end else if (w_grant_inst) begin
            r_rr_ptr <= c_port_data;
        end else if (w_grant_data) begin
            r_rr_ptr <= c_port_inst;
        end
    end
`else
    assign w_grant_data = resetn & data_req;
    assign w_grant_inst = resetn & inst_req & ~data_req;
`endif

    assign w_grant      = w_grant_inst | w_grant_data;
    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;

    always_comb begin
        mem_en    = w_grant;
        mem_we    = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (w_grant_data) begin
            mem_we    = data_wr ? data_wstrb : 4'b0000;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (w_grant_inst) begin
            mem_we    = inst_wr ? inst_wstrb : 4'b0000;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    // Stage MEM_LAT-1 lines up with the SRAM read data for that grant.
    logic [MEM_LAT-1:0] r_tag_valid;
    logic [MEM_LAT-1:0] r_tag_port;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tag_valid <= '0;
            r_tag_port  <= '0;
        end else begin
            r_tag_valid[0] <= w_grant;
            r_tag_port[0]  <= w_grant_data;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_port[i]  <= r_tag_port[i-1];
            end
        end
    end

    logic w_rsp_valid;
    logic w_rsp_port;

    assign w_rsp_valid  = r_tag_valid[MEM_LAT-1];
    assign w_rsp_port   = r_tag_port[MEM_LAT-1];
    assign inst_data_ok = w_rsp_valid & (w_rsp_port == c_port_inst);
    assign data_data_ok = w_rsp_valid & (w_rsp_port == c_port_data);

    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            if (inst_data_ok) begin
                r_inst_rdata <= mem_rdata;
            end
            if (data_data_ok) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    assign inst_rdata = inst_data_ok ? mem_rdata : r_inst_rdata;
    assign data_rdata = data_data_ok ? mem_rdata : r_data_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_arbiter
// Brief    : Directed bench; three arbiters (MEM_LAT 1..3) share one stimulus,
//            each backed by its own behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;

    logic        iaok [3];
    logic        daok [3];
    logic        idok [3];
    logic        ddok [3];
    logic        men  [3];
    logic [3:0]  mwe  [3];
    logic [31:0] maddr [3];
    logic [31:0] mwdata [3];
    logic [31:0] mrdata [3];
    logic [31:0] irdata [3];
    logic [31:0] drdata [3];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = k + 1;
        logic [31:0] mem   [256];
        logic [31:0] rpipe [LAT];

        cpu_mem_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .inst_req     (inst_req),
            .inst_wr      (inst_wr),
            .inst_wstrb   (inst_wstrb),
            .inst_addr    (inst_addr),
            .inst_wdata   (inst_wdata),
            .inst_addr_ok (iaok[k]),
            .inst_data_ok (idok[k]),
            .inst_rdata   (irdata[k]),
            .data_req     (data_req),
            .data_wr      (data_wr),
            .data_wstrb   (data_wstrb),
            .data_addr    (data_addr),
            .data_wdata   (data_wdata),
            .data_addr_ok (daok[k]),
            .data_data_ok (ddok[k]),
            .data_rdata   (drdata[k]),
            .mem_en       (men[k]),
            .mem_we       (mwe[k]),
            .mem_addr     (maddr[k]),
            .mem_wdata    (mwdata[k]),
            .mem_rdata    (mrdata[k])
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        end

        always @(posedge clk) begin
            if (men[k]) begin
                rpipe[0] <= mem[maddr[k][9:2]];
                for (int b = 0; b < 4; b++)
                    if (mwe[k][b]) mem[maddr[k][9:2]][8*b +: 8] <= mwdata[k][8*b +: 8];
            end
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end

        assign mrdata[k] = rpipe[LAT-1];
    end

    typedef struct {
        logic        ireq;  logic iwr;  logic [3:0] iws; logic [31:0] ia; logic [31:0] iwd;
        logic        dreq;  logic dwr;  logic [3:0] dws; logic [31:0] da; logic [31:0] dwd;
        logic        e_ig;  logic e_dg; logic [3:0] e_we; logic [31:0] e_addr;
        logic        e_idok; logic e_ddok; logic rchk; logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ir, input logic iw, input logic [3:0] is, input logic [31:0] ia,
                          input logic [31:0] id, input logic dr, input logic dw, input logic [3:0] ds,
                          input logic [31:0] da, input logic [31:0] dd);
        inst_req = ir; inst_wr = iw; inst_wstrb = is; inst_addr = ia; inst_wdata = id;
        data_req = dr; data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ig, n_dg;
        logic e_i;
        vec_t t;

        tbl[0]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,       1'b0,1'b0,1'b0,32'h0};
        tbl[1]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,1'b1,4'hF,32'h100,32'hDEADBEEF,
                    1'b0,1'b1,4'hF,32'h100,     1'b0,1'b0,1'b0,32'h0};
        tbl[2]  = '{1'b1,1'b0,4'h0,32'h100,32'h0,      1'b0,1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,4'h0,32'h100,     1'b0,1'b1,1'b0,32'h0};
        tbl[3]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,       1'b1,1'b0,1'b1,32'hDEADBEEF};
        tbl[4]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,1'b1,4'hF,32'h200,32'h11223344,
                    1'b0,1'b1,4'hF,32'h200,     1'b0,1'b0,1'b0,32'h0};
        tbl[5]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,1'b1,4'h2,32'h200,32'h0000AB00,
                    1'b0,1'b1,4'h2,32'h200,     1'b0,1'b1,1'b0,32'h0};
        tbl[6]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,1'b0,4'h0,32'h200,32'h0,
                    1'b0,1'b1,4'h0,32'h200,     1'b0,1'b1,1'b0,32'h0};
        tbl[7]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,       1'b0,1'b1,1'b1,32'h1122AB44};
        tbl[8]  = '{1'b1,1'b0,4'h0,32'h100,32'h0,      1'b1,1'b0,4'h0,32'h200,32'h0,
                    c_rr,!c_rr,4'h0,(c_rr ? 32'h100 : 32'h200), 1'b0,1'b0,1'b0,32'h0};
        tbl[9]  = '{!c_rr,1'b0,4'h0,32'h100,32'h0,     c_rr,1'b0,4'h0,32'h200,32'h0,
                    !c_rr,c_rr,4'h0,(c_rr ? 32'h200 : 32'h100),
                    c_rr,!c_rr,1'b1,(c_rr ? 32'hDEADBEEF : 32'h1122AB44)};
        tbl[10] = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,
                    !c_rr,c_rr,1'b1,(c_rr ? 32'h1122AB44 : 32'hDEADBEEF)};
        tbl[11] = '{1'b1,1'b1,4'hC,32'h104,32'hCAFEF00D, 1'b0,1'b0,4'h0,32'h0,32'h0,
                    1'b1,1'b0,4'hC,32'h104,     1'b0,1'b0,1'b0,32'h0};
        tbl[12] = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b1,1'b0,4'h0,32'h104,32'h0,
                    1'b0,1'b1,4'h0,32'h104,     1'b1,1'b0,1'b0,32'h0};
        tbl[13] = '{1'b0,1'b0,4'h0,32'h0,32'h0,        1'b0,1'b0,4'h0,32'h0,32'h0,
                    1'b0,1'b0,4'h0,32'h0,       1'b0,1'b1,1'b1,32'hCAFE0041};

        resetn = 1'b0;
        set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk1($sformatf("rst_iaok_%0d", k), iaok[k], 1'b0);
            chk1($sformatf("rst_daok_%0d", k), daok[k], 1'b0);
            chk1($sformatf("rst_idok_%0d", k), idok[k], 1'b0);
            chk1($sformatf("rst_ddok_%0d", k), ddok[k], 1'b0);
            chk1($sformatf("rst_mem_en_%0d", k), men[k], 1'b0);
            chk32($sformatf("rst_mem_we_%0d", k), 32'(mwe[k]), 32'h0);
        end

        // Both ports contend for 8 cycles starting in the first released cycle.
        n_ig = 0;
        n_dg = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            resetn = 1'b1;
            set_in(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
            @(negedge clk);
            e_i = c_rr ? ((c % 2) == 0) : 1'b0;
            chk1($sformatf("both_c%0d_iaok", c), iaok[0], e_i);
            chk1($sformatf("both_c%0d_daok", c), daok[0], !e_i);
            chk1($sformatf("both_c%0d_mem_en", c), men[0], 1'b1);
            if (iaok[0]) n_ig++;
            if (daok[0]) n_dg++;
        end
        chk32("both_inst_grants", n_ig, c_rr ? 32'd4 : 32'd0);
        chk32("both_data_grants", n_dg, c_rr ? 32'd4 : 32'd8);
        @(posedge clk); #1;
        set_in(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("inst_alone_iaok", iaok[0], 1'b1);
        idle(4);

        for (int v = 0; v < 14; v++) begin
            t = tbl[v];
            @(posedge clk); #1;
            set_in(t.ireq, t.iwr, t.iws, t.ia, t.iwd, t.dreq, t.dwr, t.dws, t.da, t.dwd);
            @(negedge clk);
            chk1($sformatf("v%0d_inst_addr_ok", v), iaok[0], t.e_ig);
            chk1($sformatf("v%0d_data_addr_ok", v), daok[0], t.e_dg);
            chk1($sformatf("v%0d_mem_en", v), men[0], t.e_ig | t.e_dg);
            chk32($sformatf("v%0d_mem_we", v), 32'(mwe[0]), 32'(t.e_we));
            if (t.e_ig | t.e_dg) chk32($sformatf("v%0d_mem_addr", v), maddr[0], t.e_addr);
            if (t.e_we != 4'h0) chk32($sformatf("v%0d_mem_wdata", v), mwdata[0], t.e_ig ? t.iwd : t.dwd);
            chk1($sformatf("v%0d_inst_data_ok", v), idok[0], t.e_idok);
            chk1($sformatf("v%0d_data_data_ok", v), ddok[0], t.e_ddok);
            if (t.rchk) chk32($sformatf("v%0d_rdata", v), t.e_idok ? irdata[0] : drdata[0], t.e_rd);
        end
        idle(4);

        // MEM_LAT=3: four back-to-back reads on alternating ports.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            case (c)
                0: set_in(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                1: set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
                2: set_in(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                3: set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
                default: set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            @(negedge clk);
            if (c < 4) chk1($sformatf("lat3_c%0d_addr_ok", c), ((c % 2) == 0) ? iaok[2] : daok[2], 1'b1);
            chk1($sformatf("lat3_c%0d_inst_data_ok", c), idok[2], (c == 3) || (c == 5));
            chk1($sformatf("lat3_c%0d_data_data_ok", c), ddok[2], (c == 4) || (c == 6));
            if (c >= 3 && c <= 6)
                chk32($sformatf("lat3_c%0d_rdata", c), ((c == 3) || (c == 5)) ? irdata[2] : drdata[2],
                      32'hA500_0000 + (c - 3));
        end
        idle(3);

        // MEM_LAT=2: a read is granted, then reset pulses for one cycle.
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        @(negedge clk);
        chk1("rstmid_grant", daok[1], 1'b1);
        @(posedge clk); #1;
        resetn = 1'b0;
        set_in(1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678, 1'b1, 1'b1, 4'hF, 32'h44, 32'h9ABCDEF0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk1($sformatf("rstmid_iaok_%0d", k), iaok[k], 1'b0);
            chk1($sformatf("rstmid_daok_%0d", k), daok[k], 1'b0);
            chk1($sformatf("rstmid_idok_%0d", k), idok[k], 1'b0);
            chk1($sformatf("rstmid_ddok_%0d", k), ddok[k], 1'b0);
            chk1($sformatf("rstmid_mem_en_%0d", k), men[k], 1'b0);
            chk32($sformatf("rstmid_mem_we_%0d", k), 32'(mwe[k]), 32'h0);
            chk32($sformatf("rstmid_mem_addr_%0d", k), maddr[k], 32'h0);
            chk32($sformatf("rstmid_mem_wdata_%0d", k), mwdata[k], 32'h0);
            chk32($sformatf("rstmid_irdata_%0d", k), irdata[k], 32'h0);
            chk32($sformatf("rstmid_drdata_%0d", k), drdata[k], 32'h0);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            resetn = 1'b1;
            set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk1($sformatf("post_rst_c%0d_idok_%0d", c, k), idok[k], 1'b0);
                chk1($sformatf("post_rst_c%0d_ddok_%0d", c, k), ddok[k], 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
